boot_uart_loader_ctrl: RTL and testbench
========================================

# boot_uart_loader_ctrl

- Sequences the boot UART byte stream into program-memory writes.
- Sits between the boot UART receiver (`byte_valid` / `byte_data`) and the instruction-memory write port of the CPU subsystem.
- Parses a framed load command (sync, start address, word count, data, optional checksum) and assembles little-endian 32-bit words.
- Holds the CPU in reset for the duration of a load and reports completion or error.

## Interface

- `timeout_cycles`, default 5_000_000: idle cycles allowed between bytes inside a frame before abort.
- `sync_byte`, default 8'hA5: frame start marker.
- `clk` input 1: clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `byte_valid` input 1: one-cycle pulse, a received byte is on `byte_data`.
- `byte_data` input 8: received byte.
- `mem_we` output 1: one-cycle write strobe.
- `mem_addr` output 32: word-aligned write address.
- `mem_wdata` output 32: write data.
- `cpu_reset` output 1: high while a frame is being loaded.
- `done` output 1: one-cycle pulse, frame completed without error.
- `error` output 1: sticky, last frame aborted or failed its checksum.

## Operation

- Frame format, all fields little-endian: sync byte, then 4 address bytes, then 2 count bytes N (words), then 4·N data bytes, then 1 checksum byte (only with the macro).
- **IDLE**:
  - Bytes other than `sync_byte` are ignored.
  - On `sync_byte`: clear `error`, clear the checksum accumulator, set `cpu_reset`=1, go to ADDR.
- **ADDR**:
  - Collect 4 bytes into the address register.
  - On load, `addr[1:0]` is forced to 00.
  - Go to LEN.
- **LEN**:
  - Collect 2 bytes into the 16-bit word counter.
  - N≠0: go to DATA.
  - N=0: go to CSUM with the macro; without it, finish.
- **DATA**:
  - Shift bytes into the word register; byte index 0..3, LSB first.
  - On the 4th byte: issue a write, increment the address by 4 (modulo 2^32), decrement the counter.
  - Counter reaching 0: go to CSUM, or finish without the macro.
- **CSUM**: the received byte plus the 8-bit sum of all bytes after sync must be 8'h00 (mod 256).
  - Match: finish.
  - Mismatch: set `error`, go to IDLE.
- **Finish**: pulse `done`, set `cpu_reset`=0, go to IDLE.
- **Timeout**:
  - In any state except IDLE, a counter counts cycles since the last `byte_valid`.
  - Reaching `timeout_cycles`: set `error`, set `cpu_reset`=0, go to IDLE.
  - A `byte_valid` in the same cycle as the timeout wins; the counter restarts.
- Writes already issued are not rolled back on error.
- A sync byte received mid-frame is treated as data.

## Timing

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_reset`=0, `done`=0, `error`=0; state IDLE.
- All outputs are registered.
- `mem_we` is high exactly one cycle, the cycle after the `byte_valid` of the 4th byte of a word. `mem_addr` and `mem_wdata` are stable in that cycle and held until the next write.
- `cpu_reset` rises the cycle after the sync `byte_valid` and falls together with the `done` pulse or `error` rising.
- `done` pulses the cycle after the final byte's `byte_valid`.
- `error` sets the cycle after the failing event and clears the cycle after the next sync `byte_valid` in IDLE.
- Timeout counter width is `$clog2(timeout_cycles+1)`. It is held at 0 in IDLE.
- Back-to-back `byte_valid` on consecutive cycles must be accepted with no loss.
- Deasserting `reset_n` mid-frame aborts the frame immediately; all outputs return to their reset values.

## Configuration

- `BOOT_LOADER_CHECKSUM_EN` defined:
  - CSUM state present.
  - Frame ends with the checksum byte.
  - Mismatch sets `error` and suppresses `done`.
- Not defined:
  - No CSUM state, no checksum byte, no accumulator logic.
  - Frame ends with the last data byte; for N=0, at the second count byte.

## Test plan

- **Two-word load**, macro on. Bytes A5, 00 01 00 00, 02 00, 78 56 34 12, EF BE AD DE, checksum.
  - Writes 0x12345678 @0x00000100 and 0xDEADBEEF @0x00000104.
  - Then `done` pulse, `cpu_reset` low, `error`=0.
- **Bad checksum**: same frame, checksum incremented by 1.
  - Both writes occur.
  - No `done`; `error`=1; `cpu_reset` low.
  - Next valid frame clears `error`.
- **Noise and alignment**: bytes 00, 3C before A5; address bytes 03 00 00 00; N=1.
  - Noise is ignored.
  - Write lands @0x00000000.
- **Timeout**: stop after 2 data bytes; `timeout_cycles`=100 in the bench.
  - `error` rises exactly 100 cycles after the last `byte_valid`.
  - No `mem_we`; `cpu_reset` low.
- **Zero count and back-to-back input**: N=0 with `byte_valid` on consecutive cycles.
  - Macro on: `done` pulses after the checksum byte.
  - Macro off: `done` pulses after the second count byte.
- **Reset mid-frame**: assert `reset_n`=0 during DATA.
  - All outputs return to 0 asynchronously.
  - The next frame loads correctly.

Source files
------------

// File: rtl/boot_uart_loader_ctrl.sv
// Boot UART loader: parses sync/addr/count/data[/checksum] frames into word writes.
// Optional checksum byte and CSUM state enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_uart_loader_ctrl #(
  parameter int unsigned timeout_cycles = 5_000_000,
  parameter logic [7:0]  sync_byte      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam int unsigned     TMO_W    = $clog2(timeout_cycles + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
`ifdef BOOT_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [23:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_d, cpu_reset_d, done_d, error_d;
  logic [31:0]       mem_addr_d, mem_wdata_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      tmo_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      tmo_q     <= tmo_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      cpu_reset <= cpu_reset_d;
      done      <= done_d;
      error     <= error_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    tmo_d       = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_reset_d = cpu_reset;
    done_d      = 1'b0;
    error_d     = error;
`ifdef BOOT_LOADER_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    if (state_q != S_IDLE && !byte_valid) begin
      tmo_d = TMO_W'(tmo_q + TMO_W'(1));
    end

    // A byte arriving in the expiry cycle wins over the timeout
    if (state_q != S_IDLE && !byte_valid && tmo_q == TMO_LAST) begin
      error_d     = 1'b1;
      cpu_reset_d = 1'b0;
      tmo_d       = '0;
      state_d     = S_IDLE;
    end else if (byte_valid) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
      acc_d = 8'(acc_q + byte_data);
`endif
      case (state_q)
        S_IDLE: begin
          if (byte_data == sync_byte) begin
            error_d     = 1'b0;
            cpu_reset_d = 1'b1;
            idx_d       = '0;
            state_d     = S_ADDR;
`ifdef BOOT_LOADER_CHECKSUM_EN
            acc_d       = '0;
`endif
          end
        end
        S_ADDR: begin
          addr_d = {byte_data, addr_q[31:8]};
          idx_d  = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            addr_d[1:0] = 2'b00;
            state_d     = S_LEN;
          end
        end
        S_LEN: begin
          cnt_d = {byte_data, cnt_q[15:8]};
          idx_d = 2'(idx_q + 2'd1);
          if (idx_q[0]) begin
            idx_d = '0;
            if ({byte_data, cnt_q[15:8]} != 16'd0) begin
              state_d = S_DATA;
            end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              done_d      = 1'b1;
              cpu_reset_d = 1'b0;
              state_d     = S_IDLE;
`endif
            end
          end
        end
        S_DATA: begin
          word_d = {byte_data, word_q[23:8]};
          idx_d  = 2'(idx_q + 2'd1);
          if (idx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {byte_data, word_q};
            addr_d      = addr_q + 32'd4;
            cnt_d       = cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              done_d      = 1'b1;
              cpu_reset_d = 1'b0;
              state_d     = S_IDLE;
`endif
            end
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (8'(acc_q + byte_data) == 8'h00) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          cpu_reset_d = 1'b0;
          state_d     = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_uart_loader_ctrl.sv
// Scoreboard bench for boot_uart_loader_ctrl: expected writes/done pushed by stimulus, popped by monitor.
module tb_boot_uart_loader_ctrl;

  logic        clk;
  logic        reset_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  boot_uart_loader_ctrl #(.timeout_cycles(100), .sync_byte(8'hA5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx[$];
  int         checks = 0;
  int         passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
  endfunction

  function automatic void exp_write(logic [31:0] a, logic [31:0] d);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_done();
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: every write strobe and done pulse must match the next expected event
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_kind", 32'(e.is_done), 32'd0);
          check("write_addr", mem_addr, e.addr);
          check("write_data", mem_wdata, e.data);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_kind", 32'(e.is_done), 32'd1);
        end
      end
    end
  end

  task automatic send(input bit b2b);
    for (int i = 0; i < tx.size(); i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = tx[i];
      if (!b2b) begin
        @(negedge clk);
        byte_valid = 1'b0;
      end
    end
    if (b2b) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    tx.delete();
  endtask

  task automatic load_two_word(input bit good);
    tx = '{8'hA5};
    send(1'b0);
    check("sync_cpu_reset", 32'(cpu_reset), 32'd1);
    check("sync_error_clr", 32'(error), 32'd0);
    exp_write(32'h0000_0100, 32'h1234_5678);
    exp_write(32'h0000_0104, 32'hDEAD_BEEF);
    if (good) exp_done();
    tx = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
           8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef BOOT_LOADER_CHECKSUM_EN
    tx.push_back(good ? 8'hB1 : 8'hB2);
`endif
    send(1'b0);
    check("frame_done", 32'(done), 32'(good));
    check("frame_error", 32'(error), 32'(!good));
    check("frame_cpu_reset", 32'(cpu_reset), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit early;
    reset_n    = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;

    // Two-word load
    load_two_word(1'b1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Bad checksum: writes still occur, no done, error set; next frame clears it
    load_two_word(1'b0);
    load_two_word(1'b1);
`endif

    // Timeout after two data bytes
    tx = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send(1'b0);
    early = 1'b0;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk);
      if (error) early = 1'b1;
    end
    check("tmo_not_early", 32'(early), 32'd0);
    @(negedge clk);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_cpu_reset", 32'(cpu_reset), 32'd0);

    // Noise before sync, misaligned address
    tx = '{8'h00, 8'h3C};
    send(1'b0);
    check("noise_cpu_reset", 32'(cpu_reset), 32'd0);
    check("noise_error_kept", 32'(error), 32'd1);
    tx = '{8'hA5};
    send(1'b0);
    check("noise_sync_error_clr", 32'(error), 32'd0);
    check("noise_sync_cpu_reset", 32'(cpu_reset), 32'd1);
    exp_write(32'h0000_0000, 32'h4433_2211);
    exp_done();
    tx = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
`ifdef BOOT_LOADER_CHECKSUM_EN
    tx.push_back(8'h52);
`endif
    send(1'b0);
    check("noise_done", 32'(done), 32'd1);
    check("noise_cpu_reset_low", 32'(cpu_reset), 32'd0);

    // Zero count, back-to-back bytes
    exp_done();
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
    tx.push_back(8'h00);
`endif
    send(1'b1);
    check("zero_done", 32'(done), 32'd1);
    check("zero_error", 32'(error), 32'd0);
    check("zero_cpu_reset", 32'(cpu_reset), 32'd0);

    // Reset mid-frame during DATA
    tx = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send(1'b0);
    check("pre_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    load_two_word(1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
